// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory byte-stream loader.
// Combinational only; no latency or backpressure of its own.
// Holds the FSM state encoding, default sync byte and bytes-per-word derivation.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADR_LO,
      ST_ADR_HI,
      ST_COUNT,
      ST_DATA,
      ST_WRITE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   function automatic int bytes_per_word(input int w);
      return (w + 7) / 8;
   endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Deserialises LSB-first bytes into a W-bit word; bits beyond W in the last byte drop.
// word_done is combinational with the last byte; word_dat updates on that same edge.
// No backpressure: the caller only asserts byte_vld for bytes it has accepted.
module imem_word_assembler
   import imem_loader_pkg::*;
#(
   parameter int W = 46
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         byte_vld,
   input  logic [7:0]   byte_dat,
   output logic         word_done,
   output logic [W-1:0] word_dat
);

   localparam int B  = bytes_per_word(W);
   localparam int IW = (B > 1) ? $clog2(B) : 1;

   logic [IW-1:0] idx_q;
   logic [W-1:0]  sreg_q;
   logic [W-1:0]  sreg_nxt;
   logic [W-1:0]  slot_mask;
   logic [W-1:0]  slot_dat;

   assign word_done = byte_vld && (idx_q == IW'(B - 1));

   // Slot insert by shifting in W bits, so the top byte truncates naturally.
   always_comb begin
      slot_mask = W'(8'hFF) << {idx_q, 3'b000};
      slot_dat  = W'(byte_dat) << {idx_q, 3'b000};
      sreg_nxt  = (sreg_q & ~slot_mask) | slot_dat;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q    <= '0;
         sreg_q   <= '0;
         word_dat <= '0;
      end else if (clear) begin
         idx_q <= '0;
      end else if (byte_vld) begin
         sreg_q <= sreg_nxt;
         if (word_done) begin
            idx_q    <= '0;
            word_dat <= sreg_nxt;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes W-bit words into the PAT instruction buffer.
// Write strobe follows the last byte of each word by one cycle; done pulses after CHK.
// in_ready drops only during the WRITE and DONE cycles; in_valid may stall indefinitely.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         d_width       = 8,
   parameter int         i_adr_width   = 10,
   parameter int         i_width       = 23,
   parameter int         i_buffer_size = 2,
   parameter logic [7:0] SYNC          = SYNC_BYTE
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [d_width-1:0]                 in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [i_adr_width-1:0]             imem_write_adr,
   output logic                               imem_write,
   output logic [i_buffer_size*i_width-1:0]   imem_in,
   output logic                               pat_hold,
   output logic                               load_done,
   output logic                               load_error
);

   localparam int W = i_buffer_size * i_width;

   state_t                   state_q;
   state_t                   state_nxt;
   logic                     accept;
   logic [7:0]               adr_lo_q;
   logic [7:0]               csum_q;
   logic [i_adr_width-1:0]   adr_q;
   logic [8:0]               cnt_q;
   logic                     asm_clear;
   logic                     asm_vld;
   logic                     word_done;

   assign in_ready  = (state_q != ST_WRITE) && (state_q != ST_DONE);
   assign accept    = in_valid && in_ready;
   assign asm_clear = (state_q == ST_COUNT) && accept;
   assign asm_vld   = (state_q == ST_DATA) && accept;

   assign imem_write = (state_q == ST_WRITE);
   assign pat_hold   = (state_q != ST_IDLE);
   assign load_done  = (state_q == ST_DONE);

   imem_word_assembler #(
      .W (W)
   ) u_asm (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .byte_vld  (asm_vld),
      .byte_dat  (in_data),
      .word_done (word_done),
      .word_dat  (imem_in)
   );

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:   if (accept && (in_data == SYNC)) state_nxt = ST_ADR_LO;
         ST_ADR_LO: if (accept) state_nxt = ST_ADR_HI;
         ST_ADR_HI: if (accept) state_nxt = ST_COUNT;
         ST_COUNT:  if (accept) state_nxt = ST_DATA;
         ST_DATA:   if (word_done) state_nxt = ST_WRITE;
         ST_WRITE:  state_nxt = (cnt_q == 9'd1) ? ST_CHECK : ST_DATA;
         ST_CHECK:  if (accept) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         adr_lo_q       <= '0;
         adr_q          <= '0;
         cnt_q          <= '0;
         csum_q         <= '0;
         imem_write_adr <= '0;
         load_error     <= 1'b0;
      end else begin
         state_q <= state_nxt;
         case (state_q)
            ST_IDLE: begin
               if (accept && (in_data == SYNC)) begin
                  csum_q     <= '0;
                  load_error <= 1'b0;
               end
            end
            ST_ADR_LO: begin
               if (accept) begin
                  adr_lo_q <= in_data;
                  csum_q   <= csum_q ^ in_data;
               end
            end
            ST_ADR_HI: begin
               if (accept) begin
                  adr_q  <= i_adr_width'({in_data, adr_lo_q});
                  csum_q <= csum_q ^ in_data;
               end
            end
            ST_COUNT: begin
               if (accept) begin
                  // A count byte of zero encodes the full 256-word load.
                  cnt_q  <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                  csum_q <= csum_q ^ in_data;
               end
            end
            ST_DATA: begin
               if (accept) csum_q <= csum_q ^ in_data;
               if (word_done) imem_write_adr <= adr_q;
            end
            ST_WRITE: begin
               adr_q <= adr_q + 1'b1;
               cnt_q <= cnt_q - 9'd1;
            end
            ST_CHECK: begin
               if (accept && (in_data != csum_q)) load_error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised packet stimulus against a queue-based model of the expected writes.
module tb_imem_loader;

   localparam int AW = 10;
   localparam int W  = 46;

   logic          clk;
   logic          reset;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] imem_write_adr;
   logic          imem_write;
   logic [W-1:0]  imem_in;
   logic          pat_hold;
   logic          load_done;
   logic          load_error;

   int n_checks  = 0;
   int n_errors  = 0;
   int n_strobes = 0;
   int exp_total = 0;

   logic [AW-1:0] exp_adr_q[$];
   logic [W-1:0]  exp_dat_q[$];

   imem_loader dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .imem_write_adr (imem_write_adr),
      .imem_write     (imem_write),
      .imem_in        (imem_in),
      .pat_hold       (pat_hold),
      .load_done      (load_done),
      .load_error     (load_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_write(input logic [AW-1:0] adr, input logic [W-1:0] dat);
      exp_adr_q.push_back(adr);
      exp_dat_q.push_back(dat);
      exp_total++;
   endtask

   // Write scoreboard and ready rule, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         if (imem_write) begin
            n_strobes++;
            if (exp_adr_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               check("wr_adr", imem_write_adr, exp_adr_q.pop_front());
               check("wr_dat", imem_in, exp_dat_q.pop_front());
            end
         end
         check("rdy_rule", in_ready, !(imem_write || load_done));
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit thr);
      int guard;
      guard = 0;
      @(negedge clk);
      if (thr) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check("rdy_timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit exp_err);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (load_done) found = 1'b1;
      end
      check("done_seen", found, 1);
      if (found) begin
         check("load_error", load_error, exp_err);
         check("hold_in_done", pat_hold, 1);
         @(negedge clk);
         check("hold_fall", pat_hold, 0);
         check("done_pulse", load_done, 0);
         check("err_sticky", load_error, exp_err);
      end
   endtask

   task automatic send_pkt(input logic [15:0] adr, input logic [7:0] cnt, input bit bad, input bit thr);
      int          n;
      logic [7:0]  x;
      logic [7:0]  b;
      logic [47:0] word;
      n = (cnt == 8'd0) ? 256 : int'(cnt);
      x = 8'h00;
      send_byte(8'hA5, thr);
      b = adr[7:0];  send_byte(b, thr); x ^= b;
      b = adr[15:8]; send_byte(b, thr); x ^= b;
      send_byte(cnt, thr); x ^= cnt;
      for (int w = 0; w < n; w++) begin
         word = {16'($urandom), 32'($urandom)};
         expect_write(adr[AW-1:0] + AW'(w), word[W-1:0]);
         for (int k = 0; k < 6; k++) begin
            b = word[8*k +: 8];
            send_byte(b, thr);
            x ^= b;
         end
         @(negedge clk);
         check("strobe_latency", imem_write, 1);
      end
      if (bad) x ^= 8'($urandom_range(1, 255));
      send_byte(x, thr);
      wait_done(bad);
   endtask

   logic [7:0] t1 [11];

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      $fatal(1);
   end

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      t1 = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h03};
      #12;
      check("rst_ready", in_ready, 1);
      check("rst_write", imem_write, 0);
      check("rst_adr",   imem_write_adr, 0);
      check("rst_in",    imem_in, 0);
      check("rst_hold",  pat_hold, 0);
      check("rst_done",  load_done, 0);
      check("rst_err",   load_error, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Single word with a known-good literal packet.
      expect_write(10'h005, 46'h060504030201);
      @(negedge clk);
      check("t1_idle_hold", pat_hold, 0);
      send_byte(t1[0], 0);
      @(negedge clk);
      check("t1_hold_rise", pat_hold, 1);
      for (int i = 1; i < 11; i++) send_byte(t1[i], 0);
      wait_done(0);

      // Bad checksum: write still lands, error sticks until the next SYNC.
      expect_write(10'h005, 46'h060504030201);
      for (int i = 0; i < 10; i++) send_byte(t1[i], 0);
      send_byte(8'h04, 0);
      wait_done(1);
      repeat (4) @(negedge clk);
      check("t2_err_held", load_error, 1);
      expect_write(10'h005, 46'h060504030201);
      send_byte(8'hA5, 0);
      @(negedge clk);
      check("t2_err_cleared", load_error, 0);
      for (int i = 1; i < 11; i++) send_byte(t1[i], 0);
      wait_done(0);

      // Address wrap, with upper address bits set to be ignored.
      send_pkt(16'hFFFF, 8'd2, 0, 0);

      // CNT=0 means 256 words.
      send_pkt(16'($urandom), 8'd0, 0, 0);

      // Junk before SYNC under throttled valid.
      send_byte(8'h00, 1);
      send_byte(8'hFF, 1);
      @(negedge clk);
      check("t5_junk_idle", pat_hold, 0);
      send_pkt(16'($urandom), 8'd3, 0, 1);

      repeat (6) send_pkt(16'($urandom), 8'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Reset after three data bytes of a word.
      send_byte(8'hA5, 0);
      send_byte(8'h20, 0);
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      repeat (3) send_byte(8'($urandom), 0);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_write", imem_write, 0);
      check("mid_rst_adr",   imem_write_adr, 0);
      check("mid_rst_in",    imem_in, 0);
      check("mid_rst_hold",  pat_hold, 0);
      check("mid_rst_done",  load_done, 0);
      check("mid_rst_err",   load_error, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      send_pkt(16'($urandom), 8'd2, 0, 0);

      repeat (3) @(negedge clk);
      check("exp_queue_empty", exp_adr_q.size(), 0);
      check("strobe_count", n_strobes, exp_total);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream programmer that fills the PAT instruction buffer. It accepts framed load packets on a byte-wide valid/ready port and deserialises each instruction pair into an i_buffer_size*i_width-bit word. It issues single-cycle write strobes with auto-incrementing addresses on the instruction-buffer write port (imem_write_adr / imem_write / imem_in). It sits between the off-chip programming interface and the digital top, and holds the processor idle while a load is in progress.

Parameters:
d_width, 8, stream byte width (fixed at 8; other values unsupported)
i_adr_width, 10, instruction write address width
i_width, 23, single instruction width
i_buffer_size, 2, instructions per write word; W = i_buffer_size*i_width = 46
SYNC, 8'hA5, packet start byte

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts in_data this cycle
imem_write_adr  output  i_adr_width  write address
imem_write  output  1  one-cycle write strobe
imem_in  output  W  write data
pat_hold  output  1  high while a packet is being processed; top holds the PAT in reset
load_done  output  1  one-cycle pulse at packet end
load_error  output  1  sticky checksum-mismatch flag

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low; all state is cleared immediately when reset=0.
- Reset values: state=IDLE, in_ready=1, imem_write_adr=0, imem_write=0, imem_in=0, pat_hold=0, load_done=0, load_error=0.
- Byte transfer: a byte is accepted only on a clk edge with in_valid && in_ready. One byte per cycle maximum.
- in_ready: 1 in every state except WRITE and DONE.
- Packet format, in order:
  - SYNC byte.
  - ADR_LO and ADR_HI. Address = {ADR_HI,ADR_LO}[i_adr_width-1:0]; upper bits are ignored.
  - CNT: number of words; 0 means 256.
  - CNT×B data bytes, with B = ceil(W/8) = 6. Each word is sent LSB byte first; bits above W-1 of the last byte are ignored.
  - CHK: XOR of every byte after SYNC, up to and including the last data byte.
- FSM states: IDLE, ADR_LO, ADR_HI, COUNT, DATA, WRITE, CHECK, DONE.
- IDLE: on accepting SYNC, go to ADR_LO, set pat_hold=1 and clear load_error. Any other accepted byte is discarded and the FSM stays in IDLE.
- ADR_LO -> ADR_HI -> COUNT: one accepted byte per step. ADR_HI loads the address register. COUNT loads the word counter (9 bits) and clears the byte index.
- DATA: each accepted byte is shifted into byte slot idx of the shift register. After byte B-1, go to WRITE.
- WRITE (exactly one cycle):
  - imem_write=1, with imem_in = assembled word and imem_write_adr = current address.
  - Next cycle: address increments modulo 2^i_adr_width (0x3FF wraps to 0x000) and the word counter decrements.
  - If words remain, go to DATA; otherwise go to CHECK.
- Write timing: the strobe comes one cycle after the last data byte is accepted. imem_in and imem_write_adr hold their values after the strobe until the next word.
- CHECK: on accepting the CHK byte, set load_error if CHK != running XOR, then go to DONE.
- DONE (one cycle): load_done=1, pat_hold falls in the same cycle the FSM returns to IDLE.
- Checksum errors do not roll back writes already made.
- The running XOR is cleared on SYNC.
- in_valid low mid-packet: the FSM waits indefinitely; no timeout.
- Reset mid-packet: the partial word is lost; no further write is issued.
- Simultaneous events: WRITE ignores in_valid because in_ready=0.

Decomposition:
- Package imem_loader_pkg holds the state enum, SYNC default, and the B derivation function.
- One sub-module, imem_word_assembler: byte-slot shift register, byte index counter, and word-complete flag.
- FSM, address/count counters, and checksum live in the top module.

Test Plan:
1. Single word: stream A5 05 00 01 01 02 03 04 05 06 03 -> one imem_write with adr=0x005 and imem_in=46'h060504030201; load_done pulses; load_error=0; pat_hold high from the cycle after A5 until DONE.
2. Bad checksum: same packet with CHK=0x04 -> the write still occurs; load_error=1 and stays 1; the next SYNC clears it.
3. Address wrap: adr=0x3FF, CNT=2 -> writes at 0x3FF then 0x000.
4. CNT=0: sent with 256×6 data bytes -> exactly 256 strobes at consecutive addresses, then CHECK.
5. Backpressure: in_valid toggling randomly, plus junk bytes 00 FF before SYNC -> junk is ignored; write data and addresses match the unthrottled case; in_ready=0 only in WRITE/DONE.
6. Reset mid-packet: reset low after 3 data bytes -> outputs go to reset values immediately; no strobe; a fresh packet loads correctly.
